// File: rtl/serial_rcv.sv
// serial_rcv: asynchronous serial receiver (start bit, DATA_BITS payload
// bits LSB first, one stop bit) with a single-entry output holding register.
//
// Parameters
//   BIT_PERIOD : clocks per serial bit (even, 4..255)
//   DATA_BITS  : payload bits per frame (5..8)
//
// Ports
//   clk           : system clock, all state on the rising edge
//   n_rst         : asynchronous active-low reset
//   serial_in     : already-synchronized serial line, idle high
//   data_read     : consumer acknowledges rx_data
//   rx_data       : last received payload
//   data_ready    : rx_data holds an unread frame
//   overrun_error : an unread frame was overwritten
//   framing_error : the last frame had its stop bit low
module serial_rcv #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // The counter is cleared at the edge and at every sample point, so the
    // counter value seen at the sample edge is one less than the distance.
    localparam logic [7:0] HALF_LAST = 8'(BIT_PERIOD / 2 - 1);
    localparam logic [7:0] FULL_LAST = 8'(BIT_PERIOD - 1);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

    state_t               state;
    state_t               next_state;
    logic                 prev_in;
    logic                 line_armed;
    logic [7:0]           bit_timer;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 load_pend;
    logic                 ferr_pend;
    logic                 start_clr;

    logic                 edge_det;
    logic                 sample_pt;
    logic                 timer_clear;
    logic                 shift_en;
    logic                 start_ok;
    logic                 stop_good;
    logic                 stop_bad;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A falling edge only counts once the line has been
    // seen high since reset, so a line held low through reset release cannot
    // start a frame until it rises and falls again.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (line_armed && prev_in && !serial_in) begin
                    next_state = START;
                end
            end
            START: begin
                if (bit_timer == HALF_LAST) begin
                    next_state = serial_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_timer == FULL_LAST && bit_cnt == LAST_BIT) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (bit_timer == FULL_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output/control decode: sample points and the one-cycle events they
    // produce for the datapath.
    always_comb begin
        edge_det    = 1'b0;
        sample_pt   = 1'b0;
        timer_clear = 1'b0;
        shift_en    = 1'b0;
        start_ok    = 1'b0;
        stop_good   = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE: begin
                edge_det = line_armed && prev_in && !serial_in;
            end
            START: begin
                sample_pt = (bit_timer == HALF_LAST);
                start_ok  = sample_pt && !serial_in;
            end
            DATA: begin
                sample_pt = (bit_timer == FULL_LAST);
                shift_en  = sample_pt;
            end
            STOP: begin
                sample_pt = (bit_timer == FULL_LAST);
                stop_good = sample_pt && serial_in;
                stop_bad  = sample_pt && !serial_in;
            end
            default: begin
                sample_pt = 1'b0;
            end
        endcase
        timer_clear = edge_det || sample_pt;
    end

    // Line history, bit timing and payload shift register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_in    <= 1'b1;
            line_armed <= 1'b0;
            bit_timer  <= 8'd0;
            bit_cnt    <= 4'd0;
            shift_reg  <= '0;
        end else begin
            prev_in    <= serial_in;
            line_armed <= line_armed || serial_in;
            if (timer_clear) begin
                bit_timer <= 8'd0;
            end else if (state != IDLE) begin
                bit_timer <= bit_timer + 8'd1;
            end
            if (start_ok) begin
                bit_cnt <= 4'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (shift_en) begin
                shift_reg <= {serial_in, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // Sample-point events take effect on the clock after the sample, so they
    // are carried one cycle in these pending flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            load_pend <= 1'b0;
            ferr_pend <= 1'b0;
            start_clr <= 1'b0;
        end else begin
            load_pend <= stop_good;
            ferr_pend <= stop_bad;
            start_clr <= start_ok;
        end
    end

    // Holding register and status flags. A load beats a simultaneous
    // acknowledge: the new frame is marked ready and no overrun is flagged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (load_pend) begin
                rx_data    <= shift_reg;
                data_ready <= 1'b1;
                if (data_ready) begin
                    overrun_error <= !data_read;
                end
            end else if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            if (ferr_pend) begin
                framing_error <= 1'b1;
            end else if (start_clr) begin
                framing_error <= 1'b0;
            end
        end
    end

endmodule
